// File: rtl/matrix_scan_pkg.sv
// Shared types and helpers for the dot-matrix column scanner.
package matrix_scan_pkg;

    localparam int COL_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        BLANK
    } state_t;

    // Active-low one-hot of col; bits at or above num_cols stay dark.
    function automatic logic [7:0] onehot_n(
        input logic [COL_W-1:0] col,
        input int               num_cols
    );
        logic [7:0] r;
        r = '1;
        for (int i = 0; i < 8; i++) begin
            if (i < num_cols && int'(col) == i) r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/matrix_col_scanner_dec.sv
// Registered column index to active-low one-hot column drive.
module col_onehot_dec
    import matrix_scan_pkg::*;
#(
    parameter int NUM_COLS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [COL_W-1:0]    col,
    input  logic                lit,
    output logic [NUM_COLS-1:0] col_en_n
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_en_n <= '1;
        end else if (lit) begin
            col_en_n <= NUM_COLS'(onehot_n(col, NUM_COLS));
        end else begin
            col_en_n <= '1;
        end
    end

endmodule

// File: rtl/matrix_col_scanner.sv
// Column-scan sequencer: drive, blank, advance, frame pulse on wrap.
module matrix_col_scanner
    import matrix_scan_pkg::*;
#(
    parameter int DIV       = 4,
    parameter int BLANK_CYC = 2,
    parameter int NUM_COLS  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                freeze,
    output logic [COL_W-1:0]    col_code,
    output logic [NUM_COLS-1:0] col_en_n,
    output logic                blank,
    output logic                frame_tick
);

    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLK_LAST =
        CNT_W'(BLANK_CYC > 0 ? BLANK_CYC - 1 : 0);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    state_t           state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [COL_W-1:0] nxt_col, adv_col;
    logic             nxt_tick, wrap, nxt_lit;

    assign wrap    = (col_code == COL_LAST);
    assign adv_col = wrap ? '0 : col_code + COL_W'(1);
    assign nxt_lit = (nxt_state == DRIVE);

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_col   = col_code;
        nxt_tick  = 1'b0;
        if (!en) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
            nxt_col   = '0;
        end else if (!freeze) begin
            unique case (state)
                IDLE: begin
                    nxt_state = DRIVE;
                    nxt_cnt   = '0;
                    nxt_col   = '0;
                end
                DRIVE: begin
                    if (cnt == DIV_LAST) begin
                        nxt_cnt = '0;
                        if (BLANK_CYC > 0) begin
                            nxt_state = BLANK;
                        end else begin
                            nxt_col  = adv_col;
                            nxt_tick = wrap;
                        end
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
                BLANK: begin
                    if (cnt == BLK_LAST) begin
                        nxt_state = DRIVE;
                        nxt_cnt   = '0;
                        nxt_col   = adv_col;
                        nxt_tick  = wrap;
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                    nxt_col   = '0;
                end
            endcase
        end
    end

    // Every output is registered from the same next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            col_code   <= '0;
            blank      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            col_code   <= nxt_col;
            blank      <= !nxt_lit;
            frame_tick <= nxt_tick;
        end
    end

    col_onehot_dec #(
        .NUM_COLS(NUM_COLS)
    ) u_dec (
        .clk     (clk),
        .rst_n   (rst_n),
        .col     (nxt_col),
        .lit     (nxt_lit),
        .col_en_n(col_en_n)
    );

endmodule

// File: tb/tb_matrix_col_scanner.sv
// Directed bench for matrix_col_scanner (gap and no-gap builds).
module tb_matrix_col_scanner;

    logic       clk = 1'b0;
    logic       rst_n, en, freeze, en0;
    logic [2:0] code, code0;
    logic [4:0] en_n, en_n0;
    logic       blank, blank0, tick, tick0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    matrix_col_scanner #(.DIV(4), .BLANK_CYC(2), .NUM_COLS(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .freeze    (freeze),
        .col_code  (code),
        .col_en_n  (en_n),
        .blank     (blank),
        .frame_tick(tick)
    );

    matrix_col_scanner #(.DIV(4), .BLANK_CYC(0), .NUM_COLS(5)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en0),
        .freeze    (1'b0),
        .col_code  (code0),
        .col_en_n  (en_n0),
        .blank     (blank0),
        .frame_tick(tick0)
    );

    typedef struct {
        int         cyc;
        logic [2:0] code;
        logic [4:0] en_n;
        logic       blank;
        logic       tick;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [2:0] c,
                             input logic [4:0] e, input logic b,
                             input logic t);
        check(name, {22'd0, code, en_n, blank, tick},
              {22'd0, c, e, b, t});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx, nt, nd;
        logic [4:0] exp_en;
        tbl[0]  = '{0,  3'd0, 5'b11110, 1'b0, 1'b0};
        tbl[1]  = '{3,  3'd0, 5'b11110, 1'b0, 1'b0};
        tbl[2]  = '{4,  3'd0, 5'b11111, 1'b1, 1'b0};
        tbl[3]  = '{5,  3'd0, 5'b11111, 1'b1, 1'b0};
        tbl[4]  = '{6,  3'd1, 5'b11101, 1'b0, 1'b0};
        tbl[5]  = '{12, 3'd2, 5'b11011, 1'b0, 1'b0};
        tbl[6]  = '{18, 3'd3, 5'b10111, 1'b0, 1'b0};
        tbl[7]  = '{24, 3'd4, 5'b01111, 1'b0, 1'b0};
        tbl[8]  = '{29, 3'd4, 5'b11111, 1'b1, 1'b0};
        tbl[9]  = '{30, 3'd0, 5'b11110, 1'b0, 1'b1};
        tbl[10] = '{31, 3'd0, 5'b11110, 1'b0, 1'b0};

        rst_n = 1'b0; en = 1'b0; freeze = 1'b0; en0 = 1'b0;
        step();
        step();
        check_out("reset", 3'd0, 5'b11111, 1'b1, 1'b0);
        rst_n = 1'b1;
        step();
        check_out("idle", 3'd0, 5'b11111, 1'b1, 1'b0);

        // Scan one full frame plus the first cycle of the next.
        en = 1'b1;
        idx = 0;
        nt = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            if (tick) nt++;
            if (idx < 11 && tbl[idx].cyc == k) begin
                check_out($sformatf("scan_c%0d", k), tbl[idx].code,
                          tbl[idx].en_n, tbl[idx].blank, tbl[idx].tick);
                idx++;
            end
        end
        check("tick_count", nt, 1);

        // Advance to col 2 DRIVE cnt=1 of frame two (cycle 43).
        for (int k = 32; k < 44; k++) step();
        check_out("pre_freeze", 3'd2, 5'b11011, 1'b0, 1'b0);
        freeze = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check_out($sformatf("freeze_%0d", k), 3'd2, 5'b11011,
                      1'b0, 1'b0);
        end
        freeze = 1'b0;
        nd = 1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (blank) break;
            nd++;
        end
        check("drive_after_freeze", nd, 3);
        check_out("blank_after_freeze", 3'd2, 5'b11111, 1'b1, 1'b0);

        // Restart, then drop en exactly on the wrap edge.
        en = 1'b0;
        step();
        check_out("en_off", 3'd0, 5'b11111, 1'b1, 1'b0);
        en = 1'b1;
        step();
        check_out("reenter", 3'd0, 5'b11110, 1'b0, 1'b0);
        for (int k = 1; k < 30; k++) step();
        check_out("pre_wrap", 3'd4, 5'b11111, 1'b1, 1'b0);
        en = 1'b0;
        step();
        check_out("wrap_en_off", 3'd0, 5'b11111, 1'b1, 1'b0);
        step();
        check_out("idle_hold", 3'd0, 5'b11111, 1'b1, 1'b0);
        en = 1'b1;
        step();
        check_out("restart", 3'd0, 5'b11110, 1'b0, 1'b0);

        // Async reset in the middle of col 3 DRIVE.
        for (int k = 1; k < 20; k++) step();
        check_out("col3_drive", 3'd3, 5'b10111, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 3'd0, 5'b11111, 1'b1, 1'b0);
        en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_out("post_rst_idle", 3'd0, 5'b11111, 1'b1, 1'b0);
        en = 1'b1;
        step();
        check_out("post_rst_run", 3'd0, 5'b11110, 1'b0, 1'b0);
        en = 1'b0;

        // No-gap build: 4 cycles per column, 20-cycle frame.
        en0 = 1'b1;
        nt = 0;
        for (int k = 0; k < 41; k++) begin
            step();
            exp_en = 5'b11111;
            exp_en[(k / 4) % 5] = 1'b0;
            check($sformatf("ng_c%0d", k),
                  {22'd0, code0, en_n0, blank0, tick0},
                  {22'd0, 3'((k / 4) % 5), exp_en, 1'b0,
                   1'(k > 0 && k % 20 == 0)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
